// File: rtl/row_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : row_accumulator_pkg
//  Description : Shared defaults and lane state encoding for the row reducer.
//  Revision    : 1.0  initial release
// ============================================================================
package row_accumulator_pkg;

    localparam int CH_NUM_DEF    = 4;
    localparam int VAL_W_DEF     = 16;
    localparam int LEN_W_DEF     = 8;
    localparam int ROW_IDX_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2
    } lane_state_e;

endpackage
`default_nettype wire

// File: rtl/row_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : row_accumulator_if
//  Description : Flat per-lane length/product/result buses of the row reducer.
//  Revision    : 1.0  initial release
// ============================================================================
interface row_accumulator_if
    import row_accumulator_pkg::*;
#(
    parameter int CH_NUM    = CH_NUM_DEF,
    parameter int VAL_W     = VAL_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int ACC_W     = 2*VAL_W + LEN_W,
    parameter int ROW_IDX_W = ROW_IDX_W_DEF
);
    logic [CH_NUM*LEN_W-1:0]     len;
    logic [CH_NUM-1:0]           len_empty;
    logic [CH_NUM-1:0]           len_read;
    logic [CH_NUM*2*VAL_W-1:0]   mult;
    logic [CH_NUM-1:0]           mult_empty;
    logic [CH_NUM-1:0]           mult_read;
    logic [CH_NUM*ACC_W-1:0]     sum;
    logic [CH_NUM*ROW_IDX_W-1:0] row_idx;
    logic [CH_NUM-1:0]           sum_valid;
    logic [CH_NUM-1:0]           sum_ready;

    // The reducer is the slave; FIFOs and the downstream consumer sit on the master side.
    modport slave (
        input  len, len_empty, mult, mult_empty, sum_ready,
        output len_read, mult_read, sum, row_idx, sum_valid
    );

    modport master (
        output len, len_empty, mult, mult_empty, sum_ready,
        input  len_read, mult_read, sum, row_idx, sum_valid
    );

endinterface
`default_nettype wire

// File: rtl/row_accumulator_lane.sv
`default_nettype none
// ============================================================================
//  Module      : row_accumulator_lane
//  Description : One channel: pops a row length, sums that many products, emits.
//  Revision    : 1.0  initial release
// ============================================================================
module row_accumulator_lane
    import row_accumulator_pkg::*;
#(
    parameter int VAL_W     = VAL_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int ACC_W     = 2*VAL_W + LEN_W,
    parameter int ROW_IDX_W = ROW_IDX_W_DEF
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [LEN_W-1:0]     len,
    input  wire logic                 len_empty,
    output logic                      len_read,
    input  wire logic [2*VAL_W-1:0]   mult,
    input  wire logic                 mult_empty,
    output logic                      mult_read,
    output logic [ACC_W-1:0]          sum,
    output logic [ROW_IDX_W-1:0]      row_idx,
    output logic                      sum_valid,
    input  wire logic                 sum_ready
);

    lane_state_e            state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic [ROW_IDX_W-1:0]   row_idx_q, row_idx_d;
    logic                   sum_valid_q, sum_valid_d;
    logic [ACC_W-1:0]       mult_ext;

    assign mult_ext  = ACC_W'($signed(mult));
    assign sum       = acc_q;
    assign row_idx   = row_idx_q;
    assign sum_valid = sum_valid_q;

    // Pops depend only on state and empty so they never overlap within a lane.
    always_comb begin
        len_read    = (state_q == ST_IDLE) && !len_empty;
        mult_read   = (state_q == ST_ACC)  && !mult_empty;
        state_d     = state_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        row_idx_d   = row_idx_q;
        sum_valid_d = sum_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (len_read) begin
                    acc_d = '0;
                    if (len == '0) begin
                        state_d     = ST_EMIT;
                        sum_valid_d = 1'b1;
                    end else begin
                        state_d = ST_ACC;
                        rem_d   = len;
                    end
                end
            end
            ST_ACC: begin
                if (mult_read) begin
                    acc_d = acc_q + mult_ext;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d     = ST_EMIT;
                        sum_valid_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (sum_ready) begin
                    state_d     = ST_IDLE;
                    sum_valid_d = 1'b0;
                    row_idx_d   = row_idx_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sum_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            row_idx_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            row_idx_q   <= row_idx_d;
            sum_valid_q <= sum_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/row_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : row_accumulator
//  Description : Per-channel row reduction stage; CH_NUM independent lanes.
//  Revision    : 1.0  initial release
// ============================================================================
module row_accumulator
    import row_accumulator_pkg::*;
#(
    parameter int CH_NUM    = CH_NUM_DEF,
    parameter int VAL_W     = VAL_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int ACC_W     = 2*VAL_W + LEN_W,
    parameter int ROW_IDX_W = ROW_IDX_W_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    row_accumulator_if.slave  bus
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
        row_accumulator_lane #(
            .VAL_W     (VAL_W),
            .LEN_W     (LEN_W),
            .ACC_W     (ACC_W),
            .ROW_IDX_W (ROW_IDX_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .len        (bus.len[i*LEN_W +: LEN_W]),
            .len_empty  (bus.len_empty[i]),
            .len_read   (bus.len_read[i]),
            .mult       (bus.mult[i*2*VAL_W +: 2*VAL_W]),
            .mult_empty (bus.mult_empty[i]),
            .mult_read  (bus.mult_read[i]),
            .sum        (bus.sum[i*ACC_W +: ACC_W]),
            .row_idx    (bus.row_idx[i*ROW_IDX_W +: ROW_IDX_W]),
            .sum_valid  (bus.sum_valid[i]),
            .sum_ready  (bus.sum_ready[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_row_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_row_accumulator
//  Description : Scoreboard bench: FIFO models feed lanes, monitor checks rows.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_row_accumulator;

    localparam int CH    = 4;
    localparam int VAL_W = 16;
    localparam int LEN_W = 8;
    localparam int ACC_W = 2*VAL_W + LEN_W;
    localparam int RIW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    row_accumulator_if #(.CH_NUM(CH), .VAL_W(VAL_W), .LEN_W(LEN_W),
                         .ACC_W(ACC_W), .ROW_IDX_W(RIW)) bus ();

    row_accumulator #(.CH_NUM(CH), .VAL_W(VAL_W), .LEN_W(LEN_W),
                      .ACC_W(ACC_W), .ROW_IDX_W(RIW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          lq   [CH][$];
    longint      mq   [CH][$];
    longint      esum [CH][$];
    int          eidx [CH][$];
    int          idx_next  [CH];
    int          last_pop  [CH];
    int          len_pops  [CH];
    int          mult_pops [CH];
    logic [CH-1:0] prev_v   = '0;
    logic [CH-1:0] toggle_r = '0;
    int          cyc    = 0;
    int          viol   = 0;
    int          passed = 0;
    int          total  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < CH; i++) begin
            bus.len_empty[i] = (lq[i].size() == 0);
            bus.len[i*LEN_W +: LEN_W] = (lq[i].size() != 0) ? LEN_W'(lq[i][0]) : '0;
            bus.mult_empty[i] = (mq[i].size() == 0) || (toggle_r[i] && cyc[0]);
            bus.mult[i*2*VAL_W +: 2*VAL_W] = (mq[i].size() != 0) ? (2*VAL_W)'(mq[i][0]) : '0;
        end
    endtask

    task automatic add_row(input int lane, input int n, input longint exp_sum);
        lq[lane].push_back(n);
        esum[lane].push_back(exp_sum);
        eidx[lane].push_back(idx_next[lane]);
        idx_next[lane]++;
    endtask

    task automatic add_prod(input int lane, input longint v);
        mq[lane].push_back(v);
    endtask

    task automatic clear_model();
        for (int i = 0; i < CH; i++) begin
            lq[i].delete();
            mq[i].delete();
            esum[i].delete();
            eidx[i].delete();
            idx_next[i] = 0;
        end
    endtask

    task automatic wait_done(input int limit, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < limit && !done; k++) begin
            @(negedge clk);
            #1;
            done = 1'b1;
            for (int i = 0; i < CH; i++)
                if (lq[i].size() != 0 || esum[i].size() != 0) done = 1'b0;
        end
        if (!done) begin
            total++;
            $display("FAIL %s_timeout: rows still pending after %0d cycles, expected all drained", name, limit);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string name);
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("%s_sum%0d", name, i), longint'(bus.sum[i*ACC_W +: ACC_W]), 0);
            chk($sformatf("%s_idx%0d", name, i), longint'(bus.row_idx[i*RIW +: RIW]), 0);
        end
        chk({name, "_valid"}, longint'(bus.sum_valid), 0);
        chk({name, "_len_read"}, longint'(bus.len_read), 0);
        chk({name, "_mult_read"}, longint'(bus.mult_read), 0);
    endtask

    // Upstream FWFT FIFO models: pop on read && !empty, re-drive just after the edge.
    initial begin
        for (int i = 0; i < CH; i++) begin
            last_pop[i] = 0; len_pops[i] = 0; mult_pops[i] = 0; idx_next[i] = 0;
        end
        drive();
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < CH; i++) begin
                if (bus.len_read[i] && bus.len_empty[i]) viol++;
                if (bus.mult_read[i] && bus.mult_empty[i]) viol++;
                if (bus.len_read[i] && bus.mult_read[i]) viol++;
                if (bus.len_read[i] && !bus.len_empty[i] && lq[i].size() != 0) begin
                    void'(lq[i].pop_front());
                    len_pops[i]++;
                    last_pop[i] = cyc;
                end
                if (bus.mult_read[i] && !bus.mult_empty[i] && mq[i].size() != 0) begin
                    void'(mq[i].pop_front());
                    mult_pops[i]++;
                    last_pop[i] = cyc;
                end
            end
            #1;
            drive();
        end
    end

    // Monitor: latency on each new valid, scoreboard compare on each accept.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                if (rst) begin
                    prev_v[i] = 1'b0;
                end else begin
                    if (bus.sum_valid[i] && !prev_v[i])
                        chk($sformatf("lane%0d_valid_latency_cycle", i), cyc, last_pop[i]);
                    if (bus.sum_valid[i] && bus.sum_ready[i]) begin
                        if (esum[i].size() == 0) begin
                            total++;
                            $display("FAIL lane%0d_unexpected_row: got sum %0d, expected no row", i,
                                     longint'($signed(bus.sum[i*ACC_W +: ACC_W])));
                        end else begin
                            chk($sformatf("lane%0d_sum", i),
                                longint'($signed(bus.sum[i*ACC_W +: ACC_W])), esum[i].pop_front());
                            chk($sformatf("lane%0d_row_idx", i),
                                longint'(bus.row_idx[i*RIW +: RIW]), longint'(eidx[i].pop_front()));
                        end
                    end
                    prev_v[i] = bus.sum_valid[i];
                end
            end
        end
    end

    initial begin : main
        int mp, lp;
        longint s_hold, i_hold;
        bit seen;
        bus.sum_ready = '1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Lane0: 5, -2, 7 -> 10
        mp = mult_pops[0];
        add_row(0, 3, 10);
        add_prod(0, 5); add_prod(0, -2); add_prod(0, 7);
        wait_done(100, "t1");
        chk("t1_mult_pops", mult_pops[0] - mp, 3);

        // Lane0: full-length row of maximum-magnitude products
        mp = mult_pops[0];
        add_row(0, 255, 64'sd273804165120);
        for (int k = 0; k < 255; k++) add_prod(0, 1073741824);
        wait_done(400, "t1b");
        chk("t1b_mult_pops", mult_pops[0] - mp, 255);

        // Lane1: zero-length row with a product waiting that must stay put
        mp = mult_pops[1];
        add_prod(1, 99);
        add_row(1, 0, 0);
        wait_done(50, "t2");
        chk("t2_mult_pops", mult_pops[1] - mp, 0);
        chk("t2_row_idx_after_accept", longint'(bus.row_idx[1*RIW +: RIW]), 1);
        chk("t2_valid_after_accept", longint'(bus.sum_valid[1]), 0);
        mq[1].delete();

        // Lane2: products arrive every other cycle
        mp = mult_pops[2];
        toggle_r[2] = 1'b1;
        add_row(2, 4, 131068);
        for (int k = 0; k < 4; k++) add_prod(2, 32767);
        wait_done(100, "t3");
        toggle_r[2] = 1'b0;
        chk("t3_mult_pops", mult_pops[2] - mp, 4);
        chk("t3_no_pop_while_empty", viol, 0);

        // Lane3: backpressure holds the result and blocks the next length pop
        bus.sum_ready[3] = 1'b0;
        add_row(3, 2, 30);  add_prod(3, 10); add_prod(3, 20);
        add_row(3, 1, 5);   add_prod(3, 5);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = bus.sum_valid[3];
        end
        if (!seen) begin
            total++;
            $display("FAIL t4_valid_timeout: got no valid on lane3, expected valid within 50 cycles");
        end
        s_hold = longint'($signed(bus.sum[3*ACC_W +: ACC_W]));
        i_hold = longint'(bus.row_idx[3*RIW +: RIW]);
        chk("t4_held_sum_value", s_hold, 30);
        lp = len_pops[3];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_sum_stable", longint'($signed(bus.sum[3*ACC_W +: ACC_W])), s_hold);
            chk("t4_idx_stable", longint'(bus.row_idx[3*RIW +: RIW]), i_hold);
            chk("t4_valid_held", longint'(bus.sum_valid[3]), 1);
            chk("t4_no_len_read", longint'(bus.len_read[3]), 0);
            chk("t4_no_mult_read", longint'(bus.mult_read[3]), 0);
        end
        chk("t4_len_pops_held", len_pops[3] - lp, 0);
        @(posedge clk);
        #2 bus.sum_ready[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_len_read_after_accept", longint'(bus.len_read[3]), 1);
        wait_done(50, "t4");

        // All lanes concurrently from a fresh reset: row_idx runs 0,1,2 per lane
        rst = 1'b1;
        @(posedge clk);
        #2 clear_model();
        rst = 1'b0;
        add_row(0, 1, -1);           add_prod(0, -1);
        add_row(0, 1, 100);          add_prod(0, 100);
        add_row(0, 1, -64'sd2147483648); add_prod(0, -64'sd2147483648);
        add_row(1, 2, 7);            add_prod(1, 3);    add_prod(1, 4);
        add_row(1, 2, 0);            add_prod(1, -10);  add_prod(1, 10);
        add_row(1, 2, 64'sd4294967294); add_prod(1, 2147483647); add_prod(1, 2147483647);
        add_row(2, 3, 6);            add_prod(2, 1);    add_prod(2, 2);  add_prod(2, 3);
        add_row(2, 3, -15);          add_prod(2, -5);   add_prod(2, -5); add_prod(2, -5);
        add_row(2, 3, 1000);         add_prod(2, 1000); add_prod(2, -1); add_prod(2, 1);
        add_row(3, 4, 4);
        for (int k = 0; k < 4; k++) add_prod(3, 1);
        add_row(3, 4, 0);            add_prod(3, -100); add_prod(3, 50); add_prod(3, 25); add_prod(3, 25);
        add_row(3, 4, -2);           add_prod(3, 7);    add_prod(3, -8); add_prod(3, 9);  add_prod(3, -10);
        wait_done(200, "t5");

        // Reset in the middle of a lane0 row after two of five products
        mp = mult_pops[0];
        lq[0].push_back(5);
        for (int k = 1; k <= 5; k++) add_prod(0, k);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk);
            #2;
            seen = (mult_pops[0] - mp == 2);
        end
        if (!seen) begin
            total++;
            $display("FAIL t6_pop_timeout: got %0d pops, expected 2", mult_pops[0] - mp);
        end
        rst = 1'b1;
        @(posedge clk);
        #2 clear_model();
        @(negedge clk);
        check_reset_outputs("t6_reset");
        @(posedge clk);
        #2 rst = 1'b0;
        add_row(0, 1, -3);
        add_prod(0, -3);
        wait_done(50, "t6");
        chk("final_no_illegal_pops", viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
